// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : compares two operands for a branch opcode, registers
// the decision and squashes younger instructions after a taken branch.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
   parameter int WIDTH        = 32,
   parameter int SIGNED_CMP   = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [5:0]       opcode,
   output logic             out_valid,
   output logic             taken,
   output logic             flush,
   output logic [CNT_W-1:0] cnt_branches,
   output logic [CNT_W-1:0] cnt_taken
);

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [3:0]         fcnt, fcnt_nxt;
   logic               accept;
   logic               is_branch;
   logic               cond;
   logic signed [WIDTH:0] a_ext, b_ext;

   // One extra bit lets a single signed compare serve both orderings.
   always_comb begin
      if (SIGNED_CMP != 0) begin
         a_ext = {op_a[WIDTH-1], op_a};
         b_ext = {op_b[WIDTH-1], op_b};
      end else begin
         a_ext = {1'b0, op_a};
         b_ext = {1'b0, op_b};
      end
   end

   always_comb begin
      is_branch = 1'b1;
      cond      = 1'b0;
      case (opcode)
         6'h08:   cond = (op_a == op_b);
         6'h09:   cond = (op_a != op_b);
         6'h0A:   cond = (a_ext >= b_ext);
         6'h0B:   cond = (a_ext >  b_ext);
         6'h0C:   cond = (a_ext <= b_ext);
         6'h0D:   cond = (a_ext <  b_ext);
         default: is_branch = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      in_ready  = 1'b0;
      flush     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept && is_branch && cond) begin
               state_nxt = FLUSH;
               fcnt_nxt  = FLUSH_LAST;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (fcnt == 4'd0) begin
               state_nxt = IDLE;
            end else begin
               fcnt_nxt = fcnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         fcnt         <= 4'd0;
         out_valid    <= 1'b0;
         taken        <= 1'b0;
         cnt_branches <= '0;
         cnt_taken    <= '0;
      end else begin
         state     <= state_nxt;
         fcnt      <= fcnt_nxt;
         out_valid <= accept;
         if (accept) begin
            taken <= is_branch && cond;
            // Counters stick at all-ones rather than wrapping.
            if (is_branch && (cnt_branches != {CNT_W{1'b1}}))
               cnt_branches <= cnt_branches + CNT_W'(1);
            if (is_branch && cond && (cnt_taken != {CNT_W{1'b1}}))
               cnt_taken <= cnt_taken + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit : three parameterisations driven in parallel and
// checked every cycle against a behavioural model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [5:0]  opcode = '0;

   logic        rdy_d[3], ov_d[3], tk_d[3], fl_d[3];
   logic [15:0] cb_d[3], ct_d[3];
   logic [3:0]  sat_cb, sat_ct;

   int n_vec = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.WIDTH(32), .SIGNED_CMP(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_sgn (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d[0]),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .out_valid(ov_d[0]),
      .taken(tk_d[0]), .flush(fl_d[0]), .cnt_branches(cb_d[0]), .cnt_taken(ct_d[0]));

   branch_resolve_unit #(.WIDTH(32), .SIGNED_CMP(0), .FLUSH_CYCLES(2), .CNT_W(16)) u_uns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d[1]),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .out_valid(ov_d[1]),
      .taken(tk_d[1]), .flush(fl_d[1]), .cnt_branches(cb_d[1]), .cnt_taken(ct_d[1]));

   branch_resolve_unit #(.WIDTH(32), .SIGNED_CMP(1), .FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d[2]),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .out_valid(ov_d[2]),
      .taken(tk_d[2]), .flush(fl_d[2]), .cnt_branches(sat_cb), .cnt_taken(sat_ct));

   assign cb_d[2] = {12'd0, sat_cb};
   assign ct_d[2] = {12'd0, sat_ct};

   // ---------------- behavioural model ----------------
   int flush_left[3];
   bit m_ov[3], m_tk[3];
   int m_cb[3], m_ct[3];
   int cmax[3] = '{65535, 65535, 15};
   bit sgn[3]  = '{1'b1, 1'b0, 1'b1};

   // returns {is_branch, taken}
   function automatic logic [1:0] judge(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input bit s);
      longint va, vb;
      va = s ? longint'($signed(a)) : longint'(a);
      vb = s ? longint'($signed(b)) : longint'(b);
      case (op)
         6'h08:   return {1'b1, a == b};
         6'h09:   return {1'b1, a != b};
         6'h0A:   return {1'b1, va >= vb};
         6'h0B:   return {1'b1, va >  vb};
         6'h0C:   return {1'b1, va <= vb};
         6'h0D:   return {1'b1, va <  vb};
         default: return 2'b00;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            flush_left[k] = 0; m_ov[k] = 0; m_tk[k] = 0; m_cb[k] = 0; m_ct[k] = 0;
         end else begin
            logic [1:0] r;
            bit acc;
            acc = in_valid && (flush_left[k] == 0);
            if (flush_left[k] > 0) flush_left[k]--;
            m_ov[k] = acc;
            if (acc) begin
               r = judge(opcode, op_a, op_b, sgn[k]);
               m_tk[k] = r[0];
               if (r[1] && m_cb[k] < cmax[k]) m_cb[k]++;
               if (r[0] && m_ct[k] < cmax[k]) m_ct[k]++;
               if (r[0]) flush_left[k] = 2;
            end
         end
      end
   end

   task automatic chk(input string name, input int k, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         for (int k = 0; k < 3; k++) begin
            chk("out_valid", k, longint'(ov_d[k]), longint'(m_ov[k]));
            chk("taken",     k, longint'(tk_d[k]), longint'(m_tk[k]));
            chk("flush",     k, longint'(fl_d[k]), longint'(flush_left[k] > 0));
            chk("in_ready",  k, longint'(rdy_d[k]), longint'(flush_left[k] == 0));
            chk("cnt_branches", k, longint'(cb_d[k]), longint'(m_cb[k]));
            chk("cnt_taken",    k, longint'(ct_d[k]), longint'(m_ct[k]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      opcode = op; op_a = a; op_b = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      check_en = 1'b1;
      idle(2);
      chk("rst_out_valid", 0, longint'(ov_d[0]), 0);
      chk("rst_flush",     0, longint'(fl_d[0]), 0);
      chk("rst_cnt_br",    0, longint'(cb_d[0]), 0);
      rst = 1'b0;

      // beq equal: taken, two flush cycles
      send(6'h08, 32'h0000_1234, 32'h0000_1234);
      chk("beq_ov",    0, longint'(ov_d[0]), 1);
      chk("beq_taken", 0, longint'(tk_d[0]), 1);
      chk("beq_flush", 0, longint'(fl_d[0]), 1);
      chk("beq_ready", 0, longint'(rdy_d[0]), 0);
      chk("beq_cb",    0, longint'(cb_d[0]), 1);
      chk("beq_ct",    0, longint'(ct_d[0]), 1);
      idle(1);
      chk("beq_flush2", 0, longint'(fl_d[0]), 1);
      idle(1);
      chk("beq_flush_end", 0, longint'(fl_d[0]), 0);
      chk("beq_ready_end", 0, longint'(rdy_d[0]), 1);

      // blt -1 < 1: signed taken, unsigned not
      send(6'h0D, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("blt_sgn_taken", 0, longint'(tk_d[0]), 1);
      chk("blt_uns_taken", 1, longint'(tk_d[1]), 0);
      chk("blt_uns_flush", 1, longint'(fl_d[1]), 0);
      idle(2);

      // non-branch opcode
      send(6'h23, 32'd5, 32'd5);
      chk("nb_ov",    0, longint'(ov_d[0]), 1);
      chk("nb_taken", 0, longint'(tk_d[0]), 0);
      chk("nb_flush", 0, longint'(fl_d[0]), 0);
      chk("nb_cb",    0, longint'(cb_d[0]), 2);
      chk("nb_ct",    0, longint'(ct_d[0]), 2);
      idle(1);

      // three back-to-back not-taken bne
      @(negedge clk);
      opcode = 6'h09; op_a = 32'd77; op_b = 32'd77; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("b2b_ov",    0, longint'(ov_d[0]), 1);
         chk("b2b_ready", 0, longint'(rdy_d[0]), 1);
      end
      in_valid = 1'b0;
      chk("b2b_cb", 0, longint'(cb_d[0]), 5);
      idle(1);

      // ordering variants, checked through the model
      send(6'h0A, 32'h8000_0000, 32'd1); idle(2);
      send(6'h0B, 32'd1, 32'h8000_0000); idle(2);
      send(6'h0C, 32'd7, 32'd7);         idle(2);
      send(6'h0B, 32'd3, 32'd3);         idle(2);
      send(6'h09, 32'd1, 32'd2);         idle(2);

      // request held through a flush must be accepted only once
      @(negedge clk);
      opcode = 6'h08; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
      idle(3);
      in_valid = 1'b0;
      idle(2);

      // reset during the first flush cycle
      @(negedge clk);
      opcode = 6'h0B; op_a = 32'd5; op_b = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("rstf_flush", 0, longint'(fl_d[0]), 0);
      chk("rstf_cb",    0, longint'(cb_d[0]), 0);
      chk("rstf_ct",    0, longint'(ct_d[0]), 0);
      chk("rstf_ov",    0, longint'(ov_d[0]), 0);
      idle(2);
      rst = 1'b0;
      idle(1);
      chk("rstf_ready", 0, longint'(rdy_d[0]), 1);
      idle(3);

      // saturation on the 4-bit instance
      for (int i = 0; i < 17; i++) begin
         send(6'h08, 32'd0, 32'd0);
         idle(2);
      end
      chk("sat_cb", 2, longint'(sat_cb), 15);
      chk("sat_ct", 2, longint'(sat_ct), 15);
      chk("nosat_cb", 0, longint'(cb_d[0]), 17);

      idle(2);
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (range 8..64).
REQ-002 SHALL have parameter SIGNED_CMP, default 1: 1 = two's-complement ordering for ge/gt/le/lt; 0 = unsigned ordering.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, flush length after a taken branch (range 1..15).
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  request present on op_a, op_b and opcode.
REQ-008 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-009 SHALL have port op_a  input  WIDTH  first compare operand (rs).
REQ-010 SHALL have port op_b  input  WIDTH  second compare operand (rt).
REQ-011 SHALL have port opcode  input  6  instruction bits [31:26].
REQ-012 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have port taken  output  1  branch decision; qualified by out_valid.
REQ-014 SHALL have port flush  output  1  squash younger instructions.
REQ-015 SHALL have port cnt_branches  output  CNT_W  count of accepted branch opcodes.
REQ-016 SHALL have port cnt_taken  output  CNT_W  count of taken branches.

Function
REQ-017 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; no other condition accepts a request.
REQ-018 SHALL decode opcodes 0x08 beq (a==b), 0x09 bne (a!=b), 0x0A bge (a>=b), 0x0B bgt (a>b), 0x0C ble (a<=b), 0x0D blt (a<b).
REQ-019 SHALL treat any other opcode as a non-branch: result taken=0, and neither counter changes.
REQ-020 SHALL compare ordering per SIGNED_CMP; eq/ne are independent of SIGNED_CMP.
REQ-021 SHALL register results: out_valid=1 for exactly the one cycle after the accepting edge, with taken valid in that same cycle.
REQ-022 SHALL hold taken at its last value while out_valid=0.
REQ-023 SHALL implement an FSM with states IDLE and FLUSH, plus a flush down-counter.
REQ-024 SHALL, in IDLE, drive in_ready=1 and flush=0.
REQ-025 SHALL move IDLE->FLUSH on an accepting edge with a taken result; not-taken and non-branch requests stay in IDLE.
REQ-026 SHALL, in FLUSH, drive flush=1 and in_ready=0 for exactly FLUSH_CYCLES cycles, starting in the out_valid cycle, then return to IDLE.
REQ-027 SHALL ignore in_valid while in_ready=0; the source holds the request until accepted.
REQ-028 SHALL allow back-to-back accepts while results are not taken: one result per cycle, throughput 1/cycle.
REQ-029 SHALL increment cnt_branches by 1 per accepted branch opcode.
REQ-030 SHALL increment cnt_taken by 1 per taken branch, in the same edge as cnt_branches.
REQ-031 SHALL saturate both counters at all-ones; they never wrap.

Reset
REQ-032 SHALL, while rst=1, force: state IDLE, flush counter 0, out_valid=0, taken=0, flush=0, cnt_branches=0, cnt_taken=0.
REQ-033 SHALL drive in_ready=1 from the first edge after rst deasserts.
REQ-034 SHALL, on reset during FLUSH, drop flush immediately (asynchronous); no residual flush cycles occur after release.
REQ-035 SHALL discard any result pending at reset; no out_valid pulse follows reset.

Verification
REQ-036 beq, op_a=op_b=0x0000_1234 -> next cycle out_valid=1, taken=1; flush=1 and in_ready=0 for 2 cycles; cnt_branches=1, cnt_taken=1.
REQ-037 blt with SIGNED_CMP=1, op_a=0xFFFF_FFFF, op_b=0x0000_0001 -> taken=1; same stimulus with SIGNED_CMP=0 -> taken=0, flush stays 0.
REQ-038 Opcode 0x23 with op_a=op_b -> out_valid=1, taken=0, no flush, both counters unchanged.
REQ-039 bne, equal operands, sent on 3 consecutive cycles -> 3 out_valid pulses back-to-back, all taken=0, in_ready stays 1, cnt_branches=3.
REQ-040 Taken bgt (5>3) with rst asserted during the first flush cycle -> flush=0 at once, all counters 0; after release in_ready=1 and no out_valid pulse occurs.
REQ-041 CNT_W=4, 17 taken beq -> cnt_branches=cnt_taken=0xF (saturated, not wrapped).
